// File: rtl/computie_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : computie_bus_pkg
//  Description : Shared types and constants for the Computie bus master:
//                FSM state enumeration, strobe polarity constants and the
//                default acknowledge timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
package computie_bus_pkg;

    // Default number of DATA cycles allowed before a bus error is reported.
    localparam int c_DEFAULT_TIMEOUT = 255;

    // All Computie bus strobes (al_n, ds_n, dtack_n) are active low.
    localparam logic c_STROBE_ACTIVE   = 1'b0;
    localparam logic c_STROBE_INACTIVE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_LATCH   = 3'd2,
        ST_WSETUP  = 3'd3,
        ST_TURN    = 3'd4,
        ST_DATA    = 3'd5,
        ST_DONE    = 3'd6,
        ST_RECOVER = 3'd7
    } bus_state_e;

endpackage : computie_bus_pkg
`default_nettype wire

// File: rtl/computie_bus_sync.sv
`default_nettype none
// ============================================================================
//  Module      : computie_bus_sync
//  Description : Generic two-flop synchroniser for asynchronous inputs.
//                Both stages reset to RESET_VALUE so an active-low strobe
//                reads as idle straight out of reset.
//  Ports       : clock   - system clock
//                reset   - synchronous active-high reset
//                d_i     - asynchronous input
//                q_o     - synchronised output (two clocks of latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module computie_bus_sync #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : computie_bus_sync
`default_nettype wire

// File: rtl/computie_bus_controller.sv
`default_nettype none
// ============================================================================
//  Module      : computie_bus_controller
//  Description : Bus-master sequencer for the multiplexed address/data
//                Computie bus. Runs one read or write per request: address
//                phase, address latch strobe, write setup or bus turnaround,
//                data strobe until acknowledge or timeout, then recovery
//                until the slave releases its acknowledge.
//  Ports       : clock, reset           - clock, synchronous active-high reset
//                request, write         - master request / direction (1=write)
//                address, write_data    - captured when the request is accepted
//                read_data              - last successfully read word
//                ready, bus_error       - one-cycle completion / timeout pulses
//                busy                   - transaction in progress
//                ad_oe, ad_out, ad_in   - AD pad block interface
//                al_n, ds_n, rw         - bus strobes and direction (rw 1=read)
//                dtack_n                - asynchronous slave acknowledge
//  Revision    : 1.0 - initial release
// ============================================================================
module computie_bus_controller
    import computie_bus_pkg::*;
#(
    parameter int BITWIDTH = 32,
    parameter int TIMEOUT  = c_DEFAULT_TIMEOUT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                request,
    input  logic                write,
    input  logic [BITWIDTH-1:0] address,
    input  logic [BITWIDTH-1:0] write_data,
    output logic [BITWIDTH-1:0] read_data,
    output logic                ready,
    output logic                bus_error,
    output logic                busy,
    output logic                ad_oe,
    output logic [BITWIDTH-1:0] ad_out,
    input  logic [BITWIDTH-1:0] ad_in,
    output logic                al_n,
    output logic                ds_n,
    output logic                rw,
    input  logic                dtack_n
);

    // Last counter value still inside the timeout window.
    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT - 1);

    bus_state_e          state_q;
    logic [7:0]          count_q;
    logic                write_q;
    logic [BITWIDTH-1:0] wdata_q;
    logic [BITWIDTH-1:0] read_data_q;
    logic                ready_q;
    logic                bus_error_q;
    logic                busy_q;
    logic                ad_oe_q;
    logic [BITWIDTH-1:0] ad_out_q;
    logic                al_n_q;
    logic                ds_n_q;
    logic                rw_q;
    logic                dtack_sync;

    computie_bus_sync #(
        .WIDTH       (1),
        .RESET_VALUE (1'b1)
    ) u_dtack_sync (
        .clock (clock),
        .reset (reset),
        .d_i   (dtack_n),
        .q_o   (dtack_sync)
    );

    // Outputs are assigned on entry to each state so they are valid for the
    // whole of that state's cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            read_data_q <= '0;
            ready_q     <= 1'b0;
            bus_error_q <= 1'b0;
            busy_q      <= 1'b0;
            ad_oe_q     <= 1'b0;
            ad_out_q    <= '0;
            al_n_q      <= c_STROBE_INACTIVE;
            ds_n_q      <= c_STROBE_INACTIVE;
            rw_q        <= 1'b1;
        end else begin
            // Completion flags are single-cycle pulses.
            ready_q     <= 1'b0;
            bus_error_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (request) begin
                        write_q  <= write;
                        wdata_q  <= write_data;
                        ad_out_q <= address;
                        ad_oe_q  <= 1'b1;
                        rw_q     <= ~write;
                        busy_q   <= 1'b1;
                        al_n_q   <= c_STROBE_INACTIVE;
                        state_q  <= ST_ADDR;
                    end
                end

                ST_ADDR: begin
                    al_n_q  <= c_STROBE_ACTIVE;
                    state_q <= ST_LATCH;
                end

                ST_LATCH: begin
                    al_n_q <= c_STROBE_INACTIVE;
                    if (write_q) begin
                        ad_out_q <= wdata_q;
                        state_q  <= ST_WSETUP;
                    end else begin
                        // Release the AD pins a full cycle before ds_n so
                        // the slave never fights our drivers.
                        ad_oe_q <= 1'b0;
                        state_q <= ST_TURN;
                    end
                end

                ST_WSETUP, ST_TURN: begin
                    ds_n_q  <= c_STROBE_ACTIVE;
                    count_q <= '0;
                    state_q <= ST_DATA;
                end

                ST_DATA: begin
                    // Acknowledge is tested first so it wins over a
                    // coincident timeout.
                    if (dtack_sync == c_STROBE_ACTIVE) begin
                        if (!write_q) begin
                            read_data_q <= ad_in;
                        end
                        ready_q <= 1'b1;
                    end else if (count_q == c_TIMEOUT_LAST) begin
                        bus_error_q <= 1'b1;
                    end

                    if ((dtack_sync == c_STROBE_ACTIVE) || (count_q == c_TIMEOUT_LAST)) begin
                        ds_n_q  <= c_STROBE_INACTIVE;
                        ad_oe_q <= 1'b0;
                        rw_q    <= 1'b1;
                        count_q <= '0;
                        state_q <= ST_DONE;
                    end else begin
                        count_q <= count_q + 8'd1;
                    end
                end

                ST_DONE: begin
                    state_q <= ST_RECOVER;
                end

                ST_RECOVER: begin
                    // Wait for the slave to withdraw dtack_n before the
                    // next cycle may begin.
                    if (dtack_sync == c_STROBE_INACTIVE) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign read_data = read_data_q;
    assign ready     = ready_q;
    assign bus_error = bus_error_q;
    assign busy      = busy_q;
    assign ad_oe     = ad_oe_q;
    assign ad_out    = ad_out_q;
    assign al_n      = al_n_q;
    assign ds_n      = ds_n_q;
    assign rw        = rw_q;

endmodule : computie_bus_controller
`default_nettype wire
